// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state enum and width defaults for the program loader
package loader_pkg;

    localparam int LOADER_DATA_W = 8;
    localparam int LOADER_ADDR_W = 4;
    localparam int CSUM_W        = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        CHECK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/load_csum.sv
// rtl/load_csum.sv - modular byte accumulator with clear/add and compare-to-zero
module load_csum
    import loader_pkg::*;
#(
    parameter int W = CSUM_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         add_en,
    input  logic [W-1:0] add_data,
    input  logic [W-1:0] chk_data,
    output logic         zero
);

    logic [W-1:0] acc;
    logic [W-1:0] total;

    // Running sum of image bytes, wrapping at 2**W
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= acc + add_data;
        end
    end

    // Image is good when the trailing byte brings the sum back to zero
    assign total = acc + chk_data;
    assign zero  = (total == '0);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader: streams bytes into core RAM, holds core in reset until loaded (optional checksum: LOADER_CHECKSUM_EN)
module prog_loader
    import loader_pkg::*;
#(
    parameter int DATA_W   = LOADER_DATA_W,
    parameter int ADDR_W   = LOADER_ADDR_W,
    parameter int LOAD_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_write_en,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // cnt is one bit wider than the address so a full 2**ADDR_W image terminates cleanly
    localparam logic [ADDR_W:0] LEN_C = (ADDR_W + 1)'(LOAD_LEN);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_inc;
    logic [DATA_W-1:0] byte_q;
    logic              start_ok;

    assign cnt_inc  = cnt + (ADDR_W + 1)'(1);
    assign start_ok = start && ((state == IDLE) || (state == DONE) || (state == ERR));

`ifdef LOADER_CHECKSUM_EN
    logic csum_zero;

    load_csum #(
        .W (DATA_W)
    ) u_csum (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok),
        .add_en   (state == WRITE),
        .add_data (byte_q),
        .chk_data (in_data),
        .zero     (csum_zero)
    );
`endif

    // State register; reset wins over any start in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Byte counter and holding register for the byte being written
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            byte_q <= '0;
        end else begin
            if (start_ok) begin
                cnt <= '0;
            end else if (state == WRITE) begin
                cnt <= cnt_inc;
            end
            if ((state == LOAD) && in_valid) begin
                byte_q <= in_data;
            end
        end
    end

    // Next state and state-decoded outputs; in_ready depends on state only
    always_comb begin
        state_nx     = state;
        in_ready     = 1'b0;
        ram_write_en = 1'b0;
        ram_address  = '0;
        ram_wdata    = '0;
        core_rst     = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nx = WRITE;
            end
            WRITE: begin
                ram_write_en = 1'b1;
                ram_address  = cnt[ADDR_W-1:0];
                ram_wdata    = byte_q;
                busy         = 1'b1;
                if (cnt_inc == LEN_C) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nx = CHECK;
`else
                    state_nx = DONE;
`endif
                end else begin
                    state_nx = LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nx = csum_zero ? DONE : ERR;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_nx = LOAD;
            end
`endif
            DONE: begin
                core_rst = 1'b0;
                done     = 1'b1;
                if (start) state_nx = LOAD;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the 8-bit CPU core. It accepts a byte stream over a valid/ready handshake and writes it into the core's 16 x 8 RAM through the RAM write port. It holds the core in reset until the image is fully written, then releases it. An optional checksum byte guards the image.

## Interface
Parameters:
- DATA_W, 8, RAM data width
- ADDR_W, 4, RAM address width
- LOAD_LEN, 16, image bytes written per load; legal range 1..2**ADDR_W

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- in_data  in  DATA_W  stream byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts a byte this cycle
- ram_address  out  ADDR_W  RAM write address
- ram_wdata  out  DATA_W  RAM write data; the integration muxes it onto the RAM data bus while ram_write_en=1
- ram_write_en  out  1  RAM write strobe, one cycle per byte
- core_rst  out  1  reset to the core; high until the load completes
- busy  out  1  load in progress
- done  out  1  image loaded, core released
- error  out  1  checksum mismatch; only when LOADER_CHECKSUM_EN is defined, otherwise tied 0

## Operation
- States: IDLE, LOAD, WRITE, CHECK (checksum build only), DONE, ERR.
- IDLE:
  - core_rst=1, in_ready=0.
  - start -> LOAD; byte counter cnt=0; checksum accumulator cleared.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, register in_data and go to WRITE.
- WRITE:
  - ram_write_en=1, ram_address=cnt[ADDR_W-1:0], ram_wdata=registered byte.
  - Add the byte to the accumulator (mod 2**DATA_W).
  - cnt increments.
  - If the new cnt==LOAD_LEN: go to CHECK (checksum build) or DONE; otherwise return to LOAD.
- CHECK:
  - in_ready=1.
  - On handshake: if (acc + in_data) mod 256 == 0, go to DONE; else go to ERR.
  - The checksum byte is never written to RAM.
- DONE:
  - core_rst=0, done=1.
  - start -> LOAD: core_rst reasserts the next cycle and done drops.
- ERR:
  - core_rst=1, error=1 (sticky).
  - start -> LOAD.
- start in LOAD, WRITE or CHECK is ignored.
- in_valid outside LOAD/CHECK is ignored; no byte is consumed.
- cnt is ADDR_W+1 bits wide, so LOAD_LEN=16 terminates without wrapping. ram_address never exceeds LOAD_LEN-1.

## Timing
- Reset values: state=IDLE, in_ready=0, ram_address=0, ram_wdata=0, ram_write_en=0, core_rst=1, busy=0, done=0, error=0.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid to in_ready.
- Handshake in cycle N -> ram_write_en in cycle N+1 -> in_ready again in cycle N+2. Maximum throughput is 1 byte per 2 cycles.
- The last write (or checksum handshake) in cycle N -> done=1 and core_rst=0 in cycle N+1.
- busy=1 in LOAD, WRITE and CHECK.
- rst mid-load:
  - Returns to IDLE the next cycle, with no further write strobe.
  - core_rst stays 1.
  - Partially written RAM contents are undefined to the core.
- rst has priority over start in the same cycle.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - CHECK and ERR states exist.
  - One trailing two's-complement checksum byte is consumed after LOAD_LEN bytes.
  - error is driven.
- Not defined:
  - WRITE goes straight to DONE after the last byte.
  - No trailing byte is consumed.
  - error is constant 0.
  - ERR is unreachable and omitted.

## Structure
- Shared package loader_pkg holds:
  - the state enum (IDLE, LOAD, WRITE, CHECK, DONE, ERR);
  - DATA_W/ADDR_W defaults matching the core RAM;
  - the checksum width constant.
- One sub-module, load_csum: the 8-bit modular accumulator with clear/add/compare-zero, instantiated only under LOADER_CHECKSUM_EN.

## Test plan
- Reset: rst high for 2 cycles -> all outputs at reset values, core_rst=1, in_ready=0.
- Full load, no checksum: start, then bytes 0x00..0x0F with in_valid always high -> 16 ram_write_en pulses, address i carries data i, each 2 cycles apart; done=1 and core_rst=0 one cycle after the 16th write.
- Backpressure and gaps: in_valid toggles randomly; LOAD_LEN=4 with bytes 0xA5,0x5A,0xFF,0x01 -> exactly 4 writes to addresses 0..3 with those values; no write while in_valid=0.
- Checksum pass/fail (LOADER_CHECKSUM_EN, LOAD_LEN=2):
  - Bytes 0x10,0x20 then check 0xD0 -> DONE, error=0, only 2 RAM writes.
  - Check 0xD1 -> ERR, error=1, core_rst=1.
  - A following start -> error=0, busy=1.
- Reset mid-load: rst asserted after the 3rd write of 16 -> IDLE next cycle, no 4th write, core_rst=1, done=0; a fresh start rewrites from address 0.
- Ignored start and reload: start pulsed during LOAD -> cnt unchanged. start in DONE -> core_rst=1 the next cycle and a new 16-byte load completes.
